mac_result_buffer: RTL and testbench

//  Downstream stage of the a*b+c MAC datapath.

---
 rtl/mac_result_buffer_if.sv | 27 ++
 rtl/mac_result_buffer.sv | 82 ++++++++
 tb/tb_mac_result_buffer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mac_result_buffer_if.sv
// Result-side bundle of the MAC result buffer: push strobe/data from the MAC,
// valid/ready delivery to the consumer, and occupancy/overflow status.
interface mac_result_buffer_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          validi;
    logic [DW-1:0] data_in;
    logic          readyi;
    logic          valido;
    logic [DW-1:0] data_out;
    logic [AW:0]   count_o;
    logic          full_o;
    logic          ovf_o;

    modport slave (
        input  validi, data_in, readyi,
        output valido, data_out, count_o, full_o, ovf_o
    );

    modport master (
        output validi, data_in, readyi,
        input  valido, data_out, count_o, full_o, ovf_o
    );
endinterface

// File: rtl/mac_result_buffer.sv
// First-word-fall-through result FIFO behind the MAC; the MAC never stalls.
// DROP_OLDEST_EN selects overwrite-oldest instead of discard-incoming when full.
module mac_result_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    mac_result_buffer_if.slave     bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ovf;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          ovf_evt;
    logic          wr_en;
    logic          rd_adv;
    logic [AW:0]   count_nxt;

    always_comb begin
        empty   = (count == '0);
        full    = (count == COUNT_FULL);
        push    = bus.validi;
        pop     = !empty && bus.readyi;
        ovf_evt = push && full && !pop;
`ifdef DROP_OLDEST_EN
        // Overwrite the oldest slot: when full, wr_ptr == rd_ptr, so both advance together.
        wr_en   = push;
        rd_adv  = pop || ovf_evt;
`else
        wr_en   = push && !ovf_evt;
        rd_adv  = pop;
`endif
        count_nxt = count;
        if (push && !pop && !full)
            count_nxt = count + (AW + 1)'(1);
        else if (pop && !push)
            count_nxt = count - (AW + 1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_adv)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            if (ovf_evt)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Outputs come only from registered state, so reset clears them without waiting for an edge.
    assign bus.valido   = !empty;
    assign bus.data_out = empty ? '0 : mem[rd_ptr];
    assign bus.count_o  = count;
    assign bus.full_o   = full;
    assign bus.ovf_o    = ovf;
endmodule

// File: tb/tb_mac_result_buffer.sv
// Directed, table-driven bench for mac_result_buffer; expectations follow the
// DROP_OLDEST_EN setting of the build.
module tb_mac_result_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        string       name;
        logic        rst;
        logic        validi;
        logic [31:0] data_in;
        logic        readyi;
        logic        e_valido;
        logic [31:0] e_data;
        logic [2:0]  e_count;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    vec_t vecs[$];

    mac_result_buffer_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    mac_result_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check_outs(input string name, input logic v, input logic [31:0] d,
                              input logic [2:0] c, input logic f, input logic o);
        check({name, ".valido"},   {31'd0, bus.valido}, {31'd0, v});
        check({name, ".data_out"}, bus.data_out,        d);
        check({name, ".count_o"},  {29'd0, bus.count_o}, {29'd0, c});
        check({name, ".full_o"},   {31'd0, bus.full_o}, {31'd0, f});
        check({name, ".ovf_o"},    {31'd0, bus.ovf_o},  {31'd0, o});
    endtask

    task automatic add(input string n, input logic r, input logic vi, input logic [31:0] di,
                       input logic ri, input logic ev, input logic [31:0] ed,
                       input logic [2:0] ec, input logic ef, input logic eo);
        vec_t t;
        t.name = n; t.rst = r; t.validi = vi; t.data_in = di; t.readyi = ri;
        t.e_valido = ev; t.e_data = ed; t.e_count = ec; t.e_full = ef; t.e_ovf = eo;
        vecs.push_back(t);
    endtask

    initial begin
        logic [31:0] ovf_head;
        logic [31:0] ovf_drain [4];
`ifdef DROP_OLDEST_EN
        ovf_head  = 32'd2;
        ovf_drain = '{32'd3, 32'd4, 32'd5, 32'd0};
`else
        ovf_head  = 32'd1;
        ovf_drain = '{32'd2, 32'd3, 32'd4, 32'd0};
`endif
        bus.validi  = 1'b0;
        bus.data_in = '0;
        bus.readyi  = 1'b0;

        // name            rst vi data      ri  v  data      cnt f  ovf
        add("rst0",        1, 1, 32'hAA,  1,  0, 32'd0,    0, 0, 0);
        add("rst1",        1, 1, 32'hBB,  0,  0, 32'd0,    0, 0, 0);
        add("rst2",        1, 0, 32'hCC,  1,  0, 32'd0,    0, 0, 0);
        add("pop_empty",   0, 0, 32'd0,   1,  0, 32'd0,    0, 0, 0);
        add("push7",       0, 1, 32'd7,   1,  1, 32'd7,    1, 0, 0);
        add("push11",      0, 1, 32'd11,  1,  1, 32'd11,   1, 0, 0);
        add("pop11",       0, 0, 32'd0,   1,  0, 32'd0,    0, 0, 0);
        add("fill1",       0, 1, 32'd1,   0,  1, 32'd1,    1, 0, 0);
        add("fill2",       0, 1, 32'd2,   0,  1, 32'd1,    2, 0, 0);
        add("fill3",       0, 1, 32'd3,   0,  1, 32'd1,    3, 0, 0);
        add("fill4",       0, 1, 32'd4,   0,  1, 32'd1,    4, 1, 0);
        add("hold",        0, 0, 32'd0,   0,  1, 32'd1,    4, 1, 0);
        add("drain1",      0, 0, 32'd0,   1,  1, 32'd2,    3, 0, 0);
        add("mid_pushpop", 0, 1, 32'd6,   1,  1, 32'd3,    3, 0, 0);
        add("drain2",      0, 0, 32'd0,   1,  1, 32'd4,    2, 0, 0);
        add("drain3",      0, 0, 32'd0,   1,  1, 32'd6,    1, 0, 0);
        add("drain4",      0, 0, 32'd0,   1,  0, 32'd0,    0, 0, 0);
        add("refill1",     0, 1, 32'd1,   0,  1, 32'd1,    1, 0, 0);
        add("refill2",     0, 1, 32'd2,   0,  1, 32'd1,    2, 0, 0);
        add("refill3",     0, 1, 32'd3,   0,  1, 32'd1,    3, 0, 0);
        add("refill4",     0, 1, 32'd4,   0,  1, 32'd1,    4, 1, 0);
        add("ovf_push5",   0, 1, 32'd5,   0,  1, ovf_head, 4, 1, 1);
        add("ovf_drain1",  0, 0, 32'd0,   1,  1, ovf_drain[0], 3, 0, 1);
        add("ovf_drain2",  0, 0, 32'd0,   1,  1, ovf_drain[1], 2, 0, 1);
        add("ovf_drain3",  0, 0, 32'd0,   1,  1, ovf_drain[2], 1, 0, 1);
        add("ovf_drain4",  0, 0, 32'd0,   1,  0, ovf_drain[3], 0, 0, 1);
        add("rst_ovf",     1, 0, 32'd0,   0,  0, 32'd0,    0, 0, 0);
        add("f5_1",        0, 1, 32'd1,   0,  1, 32'd1,    1, 0, 0);
        add("f5_2",        0, 1, 32'd2,   0,  1, 32'd1,    2, 0, 0);
        add("f5_3",        0, 1, 32'd3,   0,  1, 32'd1,    3, 0, 0);
        add("f5_4",        0, 1, 32'd4,   0,  1, 32'd1,    4, 1, 0);
        add("full_pp9",    0, 1, 32'd9,   1,  1, 32'd2,    4, 1, 0);
        add("f5_drain1",   0, 0, 32'd0,   1,  1, 32'd3,    3, 0, 0);
        add("f5_drain2",   0, 0, 32'd0,   1,  1, 32'd4,    2, 0, 0);
        add("f5_drain3",   0, 0, 32'd0,   1,  1, 32'd9,    1, 0, 0);
        add("f5_drain4",   0, 0, 32'd0,   1,  0, 32'd0,    0, 0, 0);

        #1;
        foreach (vecs[i]) begin
            rst         = vecs[i].rst;
            bus.validi  = vecs[i].validi;
            bus.data_in = vecs[i].data_in;
            bus.readyi  = vecs[i].readyi;
            @(posedge clk);
            #1;
            check_outs(vecs[i].name, vecs[i].e_valido, vecs[i].e_data,
                       vecs[i].e_count, vecs[i].e_full, vecs[i].e_ovf);
        end

        // Asynchronous reset between edges with two entries held.
        rst = 1'b0; bus.readyi = 1'b0; bus.validi = 1'b1; bus.data_in = 32'h11;
        @(posedge clk); #1;
        bus.data_in = 32'h22;
        @(posedge clk); #1;
        check_outs("two_held", 1'b1, 32'h11, 3'd2, 1'b0, 1'b0);
        bus.validi = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        bus.validi = 1'b1; bus.data_in = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.validi = 1'b0;
        check_outs("post_rst_push", 1'b1, 32'hDEADBEEF, 3'd1, 1'b0, 1'b0);
        bus.readyi = 1'b1;
        @(posedge clk); #1;
        check_outs("post_rst_pop", 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
